// File: rtl/fc_hdl_chan_mux.sv
// fc_hdl_chan_mux: N-channel valid/ready packet multiplexer.
// Each input channel owns a registered FIFO of {last, data}. A packet-locked
// round-robin arbiter picks one channel. Each output beat carries its source
// channel on out_ch.
// Optional feature macro: FC_HDL_CHAN_MUX_STATS_EN adds per-channel
// output beat counters (stats_clr / beat_cnt ports).
module fc_hdl_chan_mux #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch
`ifdef FC_HDL_CHAN_MUX_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [NUM_CH*32-1:0]     beat_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

  // FIFO storage and pointers (pointers carry one extra wrap bit)
  logic [DATA_W:0]   mem_q    [NUM_CH][DEPTH];
  ptr_t              wr_ptr_q [NUM_CH];
  ptr_t              rd_ptr_q [NUM_CH];

  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  // Arbiter state
  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic              hold_q, hold_d;
  logic [CH_W-1:0]   hold_ch_q, hold_ch_d;

  // Arbitration results
  logic              found;
  logic [CH_W-1:0]   pick;
  int                rr_idx;
  logic [CH_W-1:0]   gnt;
  logic              gnt_vld;
  logic              gnt_empty;
  logic [DATA_W:0]   head;
  logic              xfer;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    if (int'(c) >= NUM_CH - 1) begin
      return '0;
    end
    return c + CH_W'(1);
  endfunction

  // FIFO status flags, input handshake and per-channel eligibility
  always_comb begin
    empty    = '0;
    full     = '0;
    elig     = '0;
    in_ready = '0;
    push     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      empty[c]    = (wr_ptr_q[c] == rd_ptr_q[c]);
      full[c]     = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                    (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
      elig[c]     = !empty[c] && ch_en[c];
      in_ready[c] = rst_n && !full[c];
      push[c]     = in_valid[c] && in_ready[c];
    end
  end

  // Round-robin search: first eligible channel at or above rr_ptr, with wrap
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_idx = int'(rr_ptr_q) + i;
      if (rr_idx >= NUM_CH) begin
        rr_idx = rr_idx - NUM_CH;
      end
      if (!found && elig[rr_idx]) begin
        found = 1'b1;
        pick  = CH_W'(rr_idx);
      end
    end
  end

  // Grant selection, head-of-FIFO mux and output presentation
  always_comb begin
    gnt       = '0;
    gnt_vld   = 1'b0;
    gnt_empty = 1'b1;
    head      = '0;
    unique case (state_q)
      ST_LOCK: gnt = lock_ch_q;
      default: gnt = hold_q ? hold_ch_q : pick;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt == CH_W'(c)) begin
        head      = mem_q[c][rd_ptr_q[c][AW-1:0]];
        gnt_empty = empty[c];
      end
    end
    // A held or locked grant ignores ch_en; a fresh IDLE grant needs eligibility
    if (state_q == ST_LOCK || hold_q) begin
      gnt_vld = !gnt_empty;
    end else begin
      gnt_vld = found;
    end
    out_valid = rst_n && gnt_vld;
    out_data  = out_valid ? head[DATA_W-1:0] : '0;
    out_last  = out_valid ? head[DATA_W] : 1'b0;
    out_ch    = out_valid ? gnt : '0;
    xfer      = out_valid && out_ready;
    pop       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c] = xfer && (gnt == CH_W'(c));
    end
  end

  // Arbiter next-state: packet lock, round-robin pointer advance, grant hold
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_ch_d = lock_ch_q;
    hold_d    = out_valid && !out_ready;
    hold_ch_d = gnt;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (out_last) begin
            rr_ptr_d = next_ch(gnt);
          end else begin
            state_d   = ST_LOCK;
            lock_ch_d = gnt;
          end
        end
      end
      ST_LOCK: begin
        if (xfer && out_last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ch(lock_ch_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      lock_ch_q <= '0;
      hold_q    <= 1'b0;
      hold_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_ch_q <= lock_ch_d;
      hold_q    <= hold_d;
      hold_ch_q <= hold_ch_d;
    end
  end

  // FIFO pointers: reset empties every channel, dropping any buffered beats
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst_n) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end else begin
        if (push[c]) begin
          wr_ptr_q[c] <= wr_ptr_q[c] + ptr_t'(1);
        end
        if (pop[c]) begin
          rd_ptr_q[c] <= rd_ptr_q[c] + ptr_t'(1);
        end
      end
    end
  end

  // FIFO storage write; payload needs no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem_q[c][wr_ptr_q[c][AW-1:0]] <= {in_last[c], in_data[c*DATA_W +: DATA_W]};
      end
    end
  end

`ifdef FC_HDL_CHAN_MUX_STATS_EN
  logic [31:0] beat_cnt_q [NUM_CH];

  // Per-channel saturating output beat counters; clear wins over increment
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst_n || stats_clr) begin
        beat_cnt_q[c] <= '0;
      end else if (pop[c] && (beat_cnt_q[c] != 32'hFFFF_FFFF)) begin
        beat_cnt_q[c] <= beat_cnt_q[c] + 32'd1;
      end
    end
  end

  // Flatten counters onto the output bus
  always_comb begin
    beat_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      beat_cnt[c*32 +: 32] = beat_cnt_q[c];
    end
  end
`endif

endmodule

// File: tb/tb_fc_hdl_chan_mux.sv
// Directed testbench for fc_hdl_chan_mux (NUM_CH=3, DATA_W=16, DEPTH=4).
// Inputs change right after the falling edge; outputs are checked on the
// falling edge, i.e. they reflect the state after the preceding rising edge.
module tb_fc_hdl_chan_mux;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CH_W   = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [CH_W-1:0]          out_ch;
`ifdef FC_HDL_CHAN_MUX_STATS_EN
  logic                     stats_clr;
  logic [NUM_CH*32-1:0]     beat_cnt;
`endif

  int checks;
  int errors;

  fc_hdl_chan_mux #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_en    (ch_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_ch   (out_ch)
`ifdef FC_HDL_CHAN_MUX_STATS_EN
    ,
    .stats_clr(stats_clr),
    .beat_cnt (beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set_beat(input int c, input logic [DATA_W-1:0] d, input logic l);
    in_valid[c]                = 1'b1;
    in_data[c*DATA_W +: DATA_W] = d;
    in_last[c]                 = l;
  endtask

  task automatic chk_beat(input string tag, input logic [CH_W-1:0] ch,
                          input logic [DATA_W-1:0] d, input logic l);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_ch"},    64'(out_ch),    64'(ch));
    chk({tag, "_data"},  64'(out_data),  64'(d));
    chk({tag, "_last"},  64'(out_last),  64'(l));
  endtask

  logic [CH_W-1:0]   rr_ch [6];
  logic [DATA_W-1:0] rr_d  [6];

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    ch_en     = 3'b111;
    in_valid  = 3'b111;
    in_data   = {16'h0333, 16'h0222, 16'h0111};
    in_last   = 3'b111;
    out_ready = 1'b0;
`ifdef FC_HDL_CHAN_MUX_STATS_EN
    stats_clr = 1'b0;
`endif
    rr_ch = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    rr_d  = '{16'h0100, 16'h0101, 16'h0102, 16'h0200, 16'h0201, 16'h0202};

    // Reset with all channels offering data
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_out_ch",    64'(out_ch),    64'd0);
    rst_n    = 1'b1;
    in_valid = '0;
    @(negedge clk);
    chk("post_rst_in_ready",  64'(in_ready),  64'b111);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Round robin: two single-beat packets per channel
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        set_beat(c, 16'(16'h0100 * (b + 1) + c), 1'b1);
      end
      @(negedge clk);
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk_beat($sformatf("rr%0d", k), rr_ch[k], rr_d[k], 1'b1);
      @(negedge clk);
    end
    chk("rr_done_valid", 64'(out_valid), 64'd0);
    chk("rr_done_data",  64'(out_data),  64'd0);

    // Packet lock: ch0 4-beat packet with a 5-cycle gap before its last beat
    in_valid = '0;
    set_beat(0, 16'hC000, 1'b0);
    set_beat(1, 16'h1111, 1'b1);
    @(negedge clk);
    in_valid = '0;
    set_beat(0, 16'hC001, 1'b0);
    chk_beat("lock_b0", 2'd0, 16'hC000, 1'b0);
    @(negedge clk);
    in_valid = '0;
    set_beat(0, 16'hC002, 1'b0);
    chk_beat("lock_b1", 2'd0, 16'hC001, 1'b0);
    @(negedge clk);
    in_valid = '0;
    chk_beat("lock_b2", 2'd0, 16'hC002, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("lock_gap%0d_valid", k), 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    set_beat(0, 16'hC003, 1'b1);
    @(negedge clk);
    in_valid = '0;
    chk_beat("lock_b3", 2'd0, 16'hC003, 1'b1);
    @(negedge clk);
    chk_beat("lock_ch1", 2'd1, 16'h1111, 1'b1);
    @(negedge clk);
    chk("lock_done_valid", 64'(out_valid), 64'd0);

    // Backpressure: ch2 offers 6 beats into a depth-4 FIFO
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = '0;
      set_beat(2, 16'(16'hE000 + k), 1'b1);
      chk($sformatf("bp_ready%0d", k), 64'(in_ready[2]), (k < 4) ? 64'd1 : 64'd0);
      if (k > 0) begin
        chk($sformatf("bp_hold%0d", k), 64'(out_data), 64'hE000);
      end
      @(negedge clk);
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_beat($sformatf("bp_drain%0d", k), 2'd2, 16'(16'hE000 + k), 1'b1);
      @(negedge clk);
    end
    chk("bp_done_valid", 64'(out_valid), 64'd0);
    chk("bp_done_ready", 64'(in_ready),  64'b111);

    // ch_en mask; ch0 disabled mid-packet still finishes its packet
    out_ready = 1'b0;
    ch_en     = 3'b101;
    in_valid  = '0;
    set_beat(0, 16'hA000, 1'b0);
    set_beat(1, 16'hB000, 1'b1);
    set_beat(2, 16'hD000, 1'b1);
    @(negedge clk);
    in_valid = '0;
    set_beat(0, 16'hA001, 1'b1);
    @(negedge clk);
    in_valid = '0;
    chk_beat("en_a0", 2'd0, 16'hA000, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    ch_en = 3'b100;
    chk_beat("en_a1", 2'd0, 16'hA001, 1'b1);
    @(negedge clk);
    chk_beat("en_d0", 2'd2, 16'hD000, 1'b1);
    @(negedge clk);
    chk("en_masked_valid", 64'(out_valid), 64'd0);
    ch_en     = 3'b111;
    out_ready = 1'b0;
    @(negedge clk);
    chk_beat("en_b0", 2'd1, 16'hB000, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("en_done_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of a ch1 packet drops buffered beats and the lock
    in_valid = '0;
    set_beat(1, 16'h5000, 1'b0);
    @(negedge clk);
    in_valid = '0;
    set_beat(0, 16'h6000, 1'b1);
    chk_beat("mr_b0", 2'd1, 16'h5000, 1'b0);
    @(negedge clk);
    in_valid = '0;
    chk("mr_locked_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_post_valid", 64'(out_valid), 64'd0);
    chk("mr_post_ready", 64'(in_ready),  64'b111);
    set_beat(0, 16'h7000, 1'b1);
    @(negedge clk);
    in_valid = '0;
    chk_beat("mr_new", 2'd0, 16'h7000, 1'b1);
    @(negedge clk);
    chk("mr_done_valid", 64'(out_valid), 64'd0);

`ifdef FC_HDL_CHAN_MUX_STATS_EN
    // Counters: 10 ch1 beats, then clear coincident with the 11th transfer
    chk("st_cnt0_pre", 64'(beat_cnt[0 +: 32]), 64'd1);
    in_valid = '0;
    set_beat(1, 16'h9000, 1'b1);
    repeat (11) @(negedge clk);
    in_valid = '0;
    chk("st_cnt1_10",  64'(beat_cnt[32 +: 32]), 64'd10);
    chk("st_11_valid", 64'(out_valid),          64'd1);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("st_cnt1_clr", 64'(beat_cnt[32 +: 32]), 64'd0);
    chk("st_cnt0_clr", 64'(beat_cnt[0 +: 32]),  64'd0);
    @(negedge clk);
    chk("st_done_valid", 64'(out_valid),          64'd0);
    chk("st_cnt1_stay",  64'(beat_cnt[32 +: 32]), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
